// File: rtl/snake_pkg.sv
// Cell and colour types shared by the snake playfield renderer.
// cell_color() maps a playfield cell to its RGB565 fill colour.
package snake_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_BODY  = 2'd1,
      CELL_HEAD  = 2'd2,
      CELL_FOOD  = 2'd3
   } cell_t;

   typedef logic [15:0] rgb565_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam rgb565_t BG_COLOR     = 16'h0000;
   localparam rgb565_t BODY_COLOR   = 16'h07E0;
   localparam rgb565_t HEAD_COLOR   = 16'hF800;
   localparam rgb565_t FOOD_COLOR   = 16'hFFE0;
   localparam rgb565_t BORDER_COLOR = 16'hFF0F;
   localparam rgb565_t GRID_COLOR   = 16'h2104;

   function automatic rgb565_t cell_color(input cell_t c);
      rgb565_t col;
      case (c)
         CELL_BODY: col = BODY_COLOR;
         CELL_HEAD: col = HEAD_COLOR;
         CELL_FOOD: col = FOOD_COLOR;
         default:   col = BG_COLOR;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/grid_frame_renderer_raster_counter.sv
// Row-major (x,y) raster counter; steps on request, holds on the last pixel of the frame
// instead of wrapping, and restarts at (0,0) on clear.
module raster_counter #(
   parameter int H_RES = 320,
   parameter int V_RES = 240,
   parameter int XW    = $clog2(H_RES),
   parameter int YW    = $clog2(V_RES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          step,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   logic x_end;

   assign x_end = (x == XW'(H_RES - 1));
   assign last  = x_end && (y == YW'(V_RES - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         x <= '0;
         y <= '0;
      end else if (step && !last) begin
         if (x_end) begin
            x <= '0;
            y <= y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

endmodule

// File: rtl/grid_frame_renderer.sv
// Streams one RGB565 frame of the snake cell grid to the LCD bus per frame request, stalling on
// pix_ready without re-reading the grid RAM. Define GRID_LINES_EN to overlay cell grid lines.
module grid_frame_renderer
   import snake_pkg::*;
#(
   parameter int H_RES     = 320,
   parameter int V_RES     = 240,
   parameter int CELL_LOG2 = 3,
   parameter int GRID_W    = H_RES >> CELL_LOG2,
   parameter int GRID_H    = V_RES >> CELL_LOG2,
   parameter int XW        = $clog2(H_RES),
   parameter int YW        = $clog2(V_RES),
   parameter int AW        = $clog2(GRID_W * GRID_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame,
   input  logic          pix_ready,
   output logic          cell_rd,
   output logic [AW-1:0] cell_addr,
   input  logic [1:0]    cell_data,
   output logic [15:0]   dq,
   output logic          w_en,
   output logic          busy,
   output logic          frame_done,
   output logic [7:0]    dbg
);

   state_t        state, state_nxt;
   logic          pending, s0_active, draw_entry, advance, issue, accept_last;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          last, s0_border, s0_grid;
   logic          s1_valid, s1_fresh, s1_border, s1_grid, s1_last;
   cell_t         s1_cell, cell_sel;
   rgb565_t       color_sel, out_color;
   logic          out_valid, out_last;

   raster_counter #(.H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW)) u_raster (
      .clk   (clk),
      .rst   (rst),
      .clear (draw_entry),
      .step  (issue),
      .x     (x),
      .y     (y),
      .last  (last)
   );

   assign draw_entry  = (state == ST_IDLE) && (frame || pending);
   assign advance     = !out_valid || pix_ready;
   assign issue       = (state == ST_DRAW) && s0_active && advance;
   assign accept_last = out_valid && pix_ready && out_last;

   assign cell_rd   = issue;
   assign cell_addr = AW'(y[YW-1:CELL_LOG2]) * AW'(GRID_W) + AW'(x[XW-1:CELL_LOG2]);

   assign s0_border = (x == '0) || (x == XW'(H_RES - 1)) || (y == '0) || (y == YW'(V_RES - 1));
`ifdef GRID_LINES_EN
   assign s0_grid = (x[CELL_LOG2-1:0] == '0) || (y[CELL_LOG2-1:0] == '0);
`else
   assign s0_grid = 1'b0;
`endif

   // Read data is only on the bus for one cycle; a stalled S1 falls back to its held copy.
   always_comb begin
      cell_sel  = s1_fresh ? cell_t'(cell_data) : s1_cell;
      color_sel = cell_color(cell_sel);
      if (s1_grid)
         color_sel = GRID_COLOR;
      if (s1_border)
         color_sel = BORDER_COLOR;
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: if (frame || pending) state_nxt = ST_DRAW;
         ST_DRAW: begin
            busy = 1'b1;
            if (accept_last)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pending   <= 1'b0;
         s0_active <= 1'b0;
         s1_valid  <= 1'b0;
         s1_fresh  <= 1'b0;
         s1_border <= 1'b0;
         s1_grid   <= 1'b0;
         s1_last   <= 1'b0;
         s1_cell   <= CELL_EMPTY;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_color <= BG_COLOR;
      end else begin
         state <= state_nxt;

         if (draw_entry)
            pending <= 1'b0;
         else if (frame && state != ST_IDLE)
            pending <= 1'b1;

         if (draw_entry)
            s0_active <= 1'b1;
         else if (issue && last)
            s0_active <= 1'b0;

         s1_fresh <= issue;
         if (s1_fresh)
            s1_cell <= cell_t'(cell_data);

         if (advance) begin
            s1_valid  <= issue;
            s1_border <= s0_border;
            s1_grid   <= s0_grid;
            s1_last   <= last;
            out_valid <= s1_valid;
            out_last  <= s1_last;
            out_color <= color_sel;
         end
      end
   end

   assign w_en = !out_valid;
   assign dq   = out_valid ? out_color : 16'hzzzz;
   assign dbg  = {state, pending, out_valid, s1_valid, 3'b000};

endmodule
